// File: rtl/tw_horizontal_sender_pkg.sv
// Shared definitions for the horizontal twiddle sender.
//   - ROM2_w beat codes seen by the receiving twiddle ROM
//   - FSM state encoding of the sender
//   - identity twiddle entry (both packed factors equal to 1)
package tw_horizontal_sender_pkg;

  localparam logic [1:0] ROM2_IDLE = 2'd0;
  localparam logic [1:0] ROM2_HI   = 2'd1;
  localparam logic [1:0] ROM2_LO   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_TAIL = 2'd3
  } tw_state_e;

  localparam logic [127:0] TW_IDENTITY = 128'h0000000000000001_0000000000000001;

endpackage

// File: rtl/tw_entry_table.sv
// Twiddle table: ENTRIES x P_WIDTH registers, reset to the identity entry.
// Ports:
//   CLK      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (all entries -> identity)
//   we_i     in   write strobe (already qualified by the caller)
//   waddr_i  in   write index
//   wdata_i  in   write data
//   raddr_i  in   read index
//   rdata_o  out  combinational read data
module tw_entry_table
  import tw_horizontal_sender_pkg::*;
#(
  parameter int P_WIDTH = 128,
  parameter int ENTRIES = 4
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       we_i,
  input  logic [$clog2(ENTRIES)-1:0] waddr_i,
  input  logic [P_WIDTH-1:0]         wdata_i,
  input  logic [$clog2(ENTRIES)-1:0] raddr_i,
  output logic [P_WIDTH-1:0]         rdata_o
);

  logic [P_WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= P_WIDTH'(TW_IDENTITY);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tw_horizontal_sender.sv
// Streams the twiddle table to a receiving ROM in half-entry beats.
// A start request sends the upper halves (HI phase), the lower halves
// (LO phase), or both, each phase walking idx 0..ENTRIES-1, then a single
// TAIL cycle that carries the done pulse.
// Ports:
//   CLK, rst_n        clock / asynchronous active-low reset
//   wr_en, wr_addr,   table write port, honoured only while idle
//   wr_data
//   start, mode       transmit request; mode 1=HI, 2=LO, 3=HI then LO, 0=no-op
//   ROM2_w            registered beat code (0 idle, 1 high half, 2 low half)
//   horizontal_tf_out beat data, one cycle behind ROM2_w, zero otherwise
//   busy              transmission in progress (through TAIL)
//   done              one-cycle pulse at end of transmission
//   wr_err            one-cycle pulse after a write dropped while busy
module tw_horizontal_sender
  import tw_horizontal_sender_pkg::*;
#(
  parameter int P_WIDTH       = 128,
  parameter int horizontal_DW = P_WIDTH / 2,
  parameter int ENTRIES       = 4
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_addr,
  input  logic [P_WIDTH-1:0]         wr_data,
  input  logic                       start,
  input  logic [1:0]                 mode,
  output logic [1:0]                 ROM2_w,
  output logic [horizontal_DW-1:0]   horizontal_tf_out,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err
);

  localparam int              AW       = $clog2(ENTRIES);
  localparam logic [AW-1:0]   IDX_LAST = AW'(ENTRIES - 1);

  tw_state_e                state_q;
  logic [AW-1:0]            idx_q;
  logic [1:0]               mode_q;
  logic [1:0]               rom2_q;
  logic [horizontal_DW-1:0] data_q;
  logic [horizontal_DW-1:0] data_d;
  logic                     busy_q;
  logic                     done_q;
  logic                     wr_err_q;
  logic [P_WIDTH-1:0]       rd_data;
  logic                     tbl_we;

  // Writes are only accepted while idle, so the table is stable during a send.
  assign tbl_we = wr_en && (state_q == ST_IDLE);

  tw_entry_table #(
    .P_WIDTH (P_WIDTH),
    .ENTRIES (ENTRIES)
  ) u_table (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .we_i    (tbl_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  // Beat data for the entry tagged this cycle; it is registered, so it
  // appears one cycle after its ROM2_w code.
  always_comb begin
    data_d = '0;
    case (state_q)
      ST_HI:   data_d = rd_data[P_WIDTH-1 -: horizontal_DW];
      ST_LO:   data_d = rd_data[horizontal_DW-1:0];
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mode_q   <= 2'd0;
      rom2_q   <= ROM2_IDLE;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      done_q   <= 1'b0;
      wr_err_q <= wr_en && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode;
            idx_q  <= '0;
            case (mode)
              2'd1, 2'd3: begin
                state_q <= ST_HI;
                rom2_q  <= ROM2_HI;
                busy_q  <= 1'b1;
              end
              2'd2: begin
                state_q <= ST_LO;
                rom2_q  <= ROM2_LO;
                busy_q  <= 1'b1;
              end
              default: done_q <= 1'b1;  // no-op request still acknowledges
            endcase
          end
        end
        ST_HI: begin
          if (idx_q == IDX_LAST) begin
            idx_q <= '0;
            if (mode_q == 2'd3) begin
              state_q <= ST_LO;       // no gap between the two phases
              rom2_q  <= ROM2_LO;
            end else begin
              state_q <= ST_TAIL;
              rom2_q  <= ROM2_IDLE;
              done_q  <= 1'b1;
            end
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        ST_LO: begin
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            state_q <= ST_TAIL;
            rom2_q  <= ROM2_IDLE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: begin  // ST_TAIL
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ROM2_w            = rom2_q;
  assign horizontal_tf_out = data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign wr_err            = wr_err_q;

endmodule

// File: tb/tb_tw_horizontal_sender.sv
module tb_tw_horizontal_sender;

  localparam int P_WIDTH = 128;
  localparam int DW      = 64;
  localparam int ENTRIES = 4;

  logic           CLK = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [1:0]     wr_addr;
  logic [127:0]   wr_data;
  logic           start;
  logic [1:0]     mode;
  logic [1:0]     ROM2_w;
  logic [63:0]    horizontal_tf_out;
  logic           busy;
  logic           done;
  logic           wr_err;

  int total = 0;
  int bad   = 0;

  logic [1:0]  rom_c [16];
  logic [63:0] dat_c [16];
  logic        bsy_c [16];
  logic        dn_c  [16];
  logic        we_c  [16];

  localparam logic [63:0] ONE  = 64'h1;
  localparam logic [63:0] ZERO = 64'h0;

  tw_horizontal_sender #(
    .P_WIDTH       (P_WIDTH),
    .horizontal_DW (DW),
    .ENTRIES       (ENTRIES)
  ) dut (
    .CLK               (CLK),
    .rst_n             (rst_n),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .start             (start),
    .mode              (mode),
    .ROM2_w            (ROM2_w),
    .horizontal_tf_out (horizontal_tf_out),
    .busy              (busy),
    .done              (done),
    .wr_err            (wr_err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Pulse start for one edge, then record n cycles (index 0 = first cycle
  // after the start edge). Optional write / second start injected at a cycle.
  task automatic capture(input logic [1:0] m, input int n,
                         input int wr_cyc, input logic [1:0] wa, input logic [127:0] wd,
                         input int st_cyc, input logic [1:0] sm);
    start = 1'b1;
    mode  = m;
    step();
    start = 1'b0;
    mode  = ~m;
    for (int i = 0; i < n; i++) begin
      rom_c[i] = ROM2_w;
      dat_c[i] = horizontal_tf_out;
      bsy_c[i] = busy;
      dn_c[i]  = done;
      we_c[i]  = wr_err;
      wr_en    = (i == wr_cyc);
      wr_addr  = wa;
      wr_data  = wd;
      if (i == st_cyc) begin
        start = 1'b1;
        mode  = sm;
      end
      step();
      wr_en = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [127:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({ROM2_w, busy, done, wr_err} !== 5'b0 || horizontal_tf_out !== ZERO) begin
      bad++;
      $display("FAIL reset_outputs: got rom=%0d data=%h busy=%b done=%b wr_err=%b, want all 0",
               ROM2_w, horizontal_tf_out, busy, done, wr_err);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || ROM2_w !== 2'd0) begin
      bad++;
      $display("FAIL reset_release: got busy=%b rom=%0d, want 0 0", busy, ROM2_w);
    end
  endtask

  task automatic test_mode3_identity();
    logic [1:0]  er [10];
    logic [63:0] ed [10];
    er = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    ed = '{ZERO, ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE, ZERO};
    capture(2'd3, 10, -1, 2'd0, 128'h0, -1, 2'd0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (rom_c[i] !== er[i]) begin
        bad++;
        $display("FAIL m3_rom[%0d]: got %0d want %0d", i, rom_c[i], er[i]);
      end
      total++;
      if (dat_c[i] !== ed[i]) begin
        bad++;
        $display("FAIL m3_data[%0d]: got %h want %h", i, dat_c[i], ed[i]);
      end
      total++;
      if (dn_c[i] !== (i == 8)) begin
        bad++;
        $display("FAIL m3_done[%0d]: got %b want %b", i, dn_c[i], (i == 8));
      end
      total++;
      if (bsy_c[i] !== (i <= 8)) begin
        bad++;
        $display("FAIL m3_busy[%0d]: got %b want %b", i, bsy_c[i], (i <= 8));
      end
    end
  endtask

  task automatic test_mode1_write();
    logic [63:0] ed [7];
    int nb;
    ed = '{ZERO, ONE, ONE, 64'hfffffffeffffffc1, ONE, ZERO, ZERO};
    write_entry(2'd2, 128'hfffffffeffffffc1_007fffffffffff80);
    capture(2'd1, 7, -1, 2'd0, 128'h0, -1, 2'd0);
    nb = 0;
    for (int i = 0; i < 7; i++) begin
      if (bsy_c[i] === 1'b1) nb++;
      total++;
      if (rom_c[i] !== ((i < 4) ? 2'd1 : 2'd0)) begin
        bad++;
        $display("FAIL m1_rom[%0d]: got %0d want %0d", i, rom_c[i], (i < 4) ? 1 : 0);
      end
      total++;
      if (dat_c[i] !== ed[i]) begin
        bad++;
        $display("FAIL m1_data[%0d]: got %h want %h", i, dat_c[i], ed[i]);
      end
    end
    total++;
    if (nb != 5) begin
      bad++;
      $display("FAIL m1_busy_cycles: got %0d want 5", nb);
    end
    total++;
    if (dn_c[4] !== 1'b1) begin
      bad++;
      $display("FAIL m1_done: got %b want 1", dn_c[4]);
    end
  endtask

  // Write and start in the same idle cycle; the LO run must see the new entry.
  task automatic test_mode2_write_start();
    logic [63:0] ed [7];
    ed = '{ZERO, ONE, 64'h1234567890abcdef, 64'h007fffffffffff80, ONE, ZERO, ZERO};
    wr_en   = 1'b1;
    wr_addr = 2'd1;
    wr_data = 128'hdeadbeefcafef00d_1234567890abcdef;
    capture(2'd2, 7, -1, 2'd0, 128'h0, -1, 2'd0);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (rom_c[i] !== ((i < 4) ? 2'd2 : 2'd0)) begin
        bad++;
        $display("FAIL m2_rom[%0d]: got %0d want %0d", i, rom_c[i], (i < 4) ? 2 : 0);
      end
      total++;
      if (dat_c[i] !== ed[i]) begin
        bad++;
        $display("FAIL m2_data[%0d]: got %h want %h", i, dat_c[i], ed[i]);
      end
    end
    total++;
    if (we_c[1] !== 1'b0) begin
      bad++;
      $display("FAIL m2_no_wr_err: got %b want 0", we_c[1]);
    end
  endtask

  task automatic test_wr_busy();
    capture(2'd1, 7, 1, 2'd3, 128'haaaaaaaaaaaaaaaa_5555555555555555, -1, 2'd0);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (we_c[i] !== (i == 2)) begin
        bad++;
        $display("FAIL busy_wr_err[%0d]: got %b want %b", i, we_c[i], (i == 2));
      end
    end
    total++;
    if (dat_c[4] !== ONE) begin
      bad++;
      $display("FAIL busy_wr_data: got %h want %h", dat_c[4], ONE);
    end
    capture(2'd1, 6, -1, 2'd0, 128'h0, -1, 2'd0);
    total++;
    if (dat_c[4] !== ONE) begin
      bad++;
      $display("FAIL busy_wr_table_kept: got %h want %h", dat_c[4], ONE);
    end
  endtask

  task automatic test_start_while_busy();
    int nd;
    capture(2'd2, 10, -1, 2'd0, 128'h0, 2, 2'd3);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (dn_c[i] === 1'b1) nd++;
      total++;
      if (rom_c[i] !== ((i < 4) ? 2'd2 : 2'd0)) begin
        bad++;
        $display("FAIL ign_start_rom[%0d]: got %0d want %0d", i, rom_c[i], (i < 4) ? 2 : 0);
      end
    end
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL ign_start_done_count: got %0d want 1", nd);
    end
  endtask

  task automatic test_mode0();
    capture(2'd0, 3, -1, 2'd0, 128'h0, -1, 2'd0);
    total++;
    if (dn_c[0] !== 1'b1 || dn_c[1] !== 1'b0) begin
      bad++;
      $display("FAIL m0_done: got %b%b want 10", dn_c[0], dn_c[1]);
    end
    total++;
    if (bsy_c[0] !== 1'b0 || bsy_c[1] !== 1'b0 || rom_c[0] !== 2'd0) begin
      bad++;
      $display("FAIL m0_idle: got busy=%b%b rom=%0d want 00 0", bsy_c[0], bsy_c[1], rom_c[0]);
    end
  endtask

  // Start immediately in the first idle cycle after TAIL.
  task automatic test_back_to_back();
    capture(2'd2, 8, -1, 2'd0, 128'h0, 5, 2'd1);
    total++;
    if (dn_c[4] !== 1'b1 || bsy_c[5] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first_end: got done=%b busy=%b want 1 0", dn_c[4], bsy_c[5]);
    end
    total++;
    if (rom_c[6] !== 2'd1 || bsy_c[6] !== 1'b1 || rom_c[7] !== 2'd1) begin
      bad++;
      $display("FAIL b2b_second_start: got rom=%0d/%0d busy=%b want 1/1 1",
               rom_c[6], rom_c[7], bsy_c[6]);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset_mid();
    int nd;
    write_entry(2'd2, 128'hfffffffeffffffc1_007fffffffffff80);
    start = 1'b1;
    mode  = 2'd1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (ROM2_w !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || horizontal_tf_out !== ZERO) begin
      bad++;
      $display("FAIL reset_mid_async: got rom=%0d busy=%b done=%b data=%h want 0",
               ROM2_w, busy, done, horizontal_tf_out);
    end
    step();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) nd++;
      step();
    end
    total++;
    if (nd != 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d want 0", nd);
    end
    capture(2'd1, 6, -1, 2'd0, 128'h0, -1, 2'd0);
    total++;
    if (dat_c[3] !== ONE) begin
      bad++;
      $display("FAIL reset_table_identity: got %h want %h", dat_c[3], ONE);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 2'd0;
    wr_data = '0;
    start   = 1'b0;
    mode    = 2'd0;
    test_reset();
    test_mode3_identity();
    test_mode1_write();
    test_mode2_write_start();
    test_wr_busy();
    test_start_while_busy();
    test_mode0();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
